// File: rtl/scurve_pkg.sv
// Shared types and constants for the S-curve threshold sweep controller.
package scurve_pkg;
  localparam int CHN_NUM      = 64;
  localparam int DAC_W        = 10;
  localparam int CHN_W        = 6;
  localparam int TAG_W        = DAC_W + CHN_W;
  localparam int SETTLE_CNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONFIG,
    S_WAIT_CFG,
    S_SETTLE,
    S_TAG,
    S_START,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } sweep_state_t;

  // A zero step would never advance the threshold, so it is treated as 1.
  function automatic logic [DAC_W-1:0] eff_step(input logic [DAC_W-1:0] step);
    return (step == '0) ? DAC_W'(1) : step;
  endfunction
endpackage

// File: rtl/sweep_settle_timer.sv
// Settle delay counter: load restarts it, expired is high on the cnt_max-th cycle after load.
module sweep_settle_timer
  import scurve_pkg::*;
#(
  parameter int CNT_W = SETTLE_CNT_W
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_max,
  output logic             expired
);
  logic [CNT_W-1:0] cnt_q;

  // A cnt_max of 0 behaves like 1 so the settle phase always ends.
  assign expired = ((cnt_q + 1'b1) >= cnt_max);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/scurve_sweep_ctrl.sv
// Sweeps DAC threshold (outer loop) and channel (inner loop), sequencing configure,
// settle, tag and single-point test for every point.
module scurve_sweep_ctrl
  import scurve_pkg::*;
#(
  parameter int CHN_NUM       = scurve_pkg::CHN_NUM,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             Sweep_Start,
  input  logic             Sweep_Abort,
  input  logic             Single_Chn_Mode,
  input  logic [CHN_W-1:0] Single_Chn,
  input  logic [DAC_W-1:0] DAC_Start,
  input  logic [DAC_W-1:0] DAC_Stop,
  input  logic [DAC_W-1:0] DAC_Step,
  input  logic             Config_Done,
  input  logic             One_Channel_Done,
  output logic [CHN_W-1:0] Channel_Sel,
  output logic [DAC_W-1:0] DAC_Code,
  output logic             Config_Req,
  output logic             SCurve_Test_Start,
  output logic [TAG_W-1:0] Tag_Data,
  output logic             Tag_wr_en,
  output logic             Busy,
  output logic             Sweep_Done,
  output logic [3:0]       state_dbg
);
  sweep_state_t     state_q, state_d;
  logic             start_q1, start_q2, start_rise;
  logic             mode_q;
  logic [CHN_W-1:0] single_q, chn_q, chn_d;
  logic [DAC_W-1:0] stop_q, step_q, dac_q, dac_d;
  logic [DAC_W:0]   dac_sum;
  logic             latch_en, abort, done_q;
  logic             settle_load, settle_expired;

  // Edge detector resets to "high" so a level already present at release is not an edge.
  assign start_rise = start_q1 & ~start_q2;
  assign abort      = Sweep_Abort && (state_q != S_IDLE);
  assign dac_sum    = {1'b0, dac_q} + {1'b0, eff_step(step_q)};

  always_comb begin
    state_d  = state_q;
    chn_d    = chn_q;
    dac_d    = dac_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          latch_en = 1'b1;
          dac_d    = DAC_Start;
          chn_d    = Single_Chn_Mode ? Single_Chn : '0;
          state_d  = (DAC_Stop < DAC_Start) ? S_FINISH : S_CONFIG;
        end
      end
      S_CONFIG:    state_d = S_WAIT_CFG;
      S_WAIT_CFG:  if (Config_Done) state_d = S_SETTLE;
      S_SETTLE:    if (settle_expired) state_d = S_TAG;
      S_TAG:       state_d = S_START;
      S_START:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (One_Channel_Done) state_d = S_NEXT;
      S_NEXT: begin
        if (!mode_q && (chn_q < CHN_W'(CHN_NUM - 1))) begin
          chn_d   = chn_q + 1'b1;
          state_d = S_CONFIG;
        end else if (!dac_sum[DAC_W] && (dac_sum[DAC_W-1:0] <= stop_q)) begin
          dac_d   = dac_sum[DAC_W-1:0];
          chn_d   = mode_q ? single_q : '0;
          state_d = S_CONFIG;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      chn_d    = chn_q;
      dac_d    = dac_q;
      latch_en = 1'b0;
    end
  end

  assign settle_load = (state_d == S_SETTLE) && (state_q != S_SETTLE);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      start_q1 <= 1'b1;
      start_q2 <= 1'b1;
      mode_q   <= 1'b0;
      single_q <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      chn_q    <= '0;
      dac_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q1 <= Sweep_Start;
      start_q2 <= start_q1;
      chn_q    <= chn_d;
      dac_q    <= dac_d;
      done_q   <= (state_q == S_FINISH) || abort;
      if (latch_en) begin
        mode_q   <= Single_Chn_Mode;
        single_q <= Single_Chn;
        stop_q   <= DAC_Stop;
        step_q   <= DAC_Step;
      end
    end
  end

  sweep_settle_timer #(.CNT_W(SETTLE_CNT_W)) u_settle (
    .Clk     (Clk),
    .reset_n (reset_n),
    .load    (settle_load),
    .cnt_max (SETTLE_CNT_W'(SETTLE_CYCLES)),
    .expired (settle_expired)
  );

  assign Channel_Sel       = chn_q;
  assign DAC_Code          = dac_q;
  assign Tag_Data          = {dac_q, chn_q};
  assign Config_Req        = (state_q == S_CONFIG);
  assign Tag_wr_en         = (state_q == S_TAG);
  assign SCurve_Test_Start = (state_q == S_START);
  assign Busy              = (state_q != S_IDLE);
  assign Sweep_Done        = done_q;
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// Randomized bench for scurve_sweep_ctrl with an arithmetic point-list model and tag scoreboard.
module tb_scurve_sweep_ctrl;
  import scurve_pkg::*;

  localparam int TB_CHN = 64;
  localparam int SETTLE = 16;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Sweep_Start = 1'b0;
  logic        Sweep_Abort = 1'b0;
  logic        Single_Chn_Mode = 1'b0;
  logic [5:0]  Single_Chn = '0;
  logic [9:0]  DAC_Start = '0;
  logic [9:0]  DAC_Stop = '0;
  logic [9:0]  DAC_Step = '0;
  logic        Config_Done, One_Channel_Done;
  logic [5:0]  Channel_Sel;
  logic [9:0]  DAC_Code;
  logic        Config_Req, SCurve_Test_Start, Tag_wr_en, Busy, Sweep_Done;
  logic [15:0] Tag_Data;
  logic [3:0]  state_dbg;

  logic cfg_auto = 1'b0, cfg_man = 1'b0, ocd_auto = 1'b0, ocd_man = 1'b0;
  bit   auto_cfg = 1'b1, auto_done = 1'b1;
  int   max_delay = 0;

  assign Config_Done      = cfg_auto | cfg_man;
  assign One_Channel_Done = ocd_auto | ocd_man;

  int n_checks = 0, n_errors = 0;
  int cfg_req_cnt = 0, start_cnt = 0, done_cnt = 0, tag_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp = '0, first_tag = '0, last_tag = '0;

  scurve_sweep_ctrl #(.CHN_NUM(TB_CHN), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk(Clk), .reset_n(reset_n), .Sweep_Start(Sweep_Start), .Sweep_Abort(Sweep_Abort),
    .Single_Chn_Mode(Single_Chn_Mode), .Single_Chn(Single_Chn), .DAC_Start(DAC_Start),
    .DAC_Stop(DAC_Stop), .DAC_Step(DAC_Step), .Config_Done(Config_Done),
    .One_Channel_Done(One_Channel_Done), .Channel_Sel(Channel_Sel), .DAC_Code(DAC_Code),
    .Config_Req(Config_Req), .SCurve_Test_Start(SCurve_Test_Start), .Tag_Data(Tag_Data),
    .Tag_wr_en(Tag_wr_en), .Busy(Busy), .Sweep_Done(Sweep_Done), .state_dbg(state_dbg)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {27'd0, Channel_Sel, DAC_Code, Config_Req, SCurve_Test_Start, Tag_Data,
            Tag_wr_en, Busy, Sweep_Done};
  endfunction

  // Expected tag list straight from the sweep rules, using unbounded int arithmetic.
  task automatic build_model(input bit mode, input int ch, input int st, input int sp,
                             input int stp, output int n);
    int s;
    s = (stp == 0) ? 1 : stp;
    n = 0;
    for (int d = st; d <= sp; d += s) begin
      if (mode) begin
        exp_q.push_back({10'(d), 6'(ch)});
        n++;
      end else begin
        for (int c = 0; c < TB_CHN; c++) begin
          exp_q.push_back({10'(d), 6'(c)});
          n++;
        end
      end
    end
  endtask

  // Configurator and test-stage responders (respond once the DUT has moved into its wait state).
  initial forever begin
    @(negedge Clk);
    if (reset_n && auto_cfg && Config_Req) begin
      repeat (1 + $urandom_range(0, max_delay)) @(negedge Clk);
      cfg_auto = 1'b1;
      @(negedge Clk);
      cfg_auto = 1'b0;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (reset_n && auto_done && SCurve_Test_Start) begin
      repeat (1 + $urandom_range(0, max_delay)) @(negedge Clk);
      ocd_auto = 1'b1;
      @(negedge Clk);
      ocd_auto = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (reset_n) begin
      if (Config_Req) cfg_req_cnt++;
      if (Sweep_Done) done_cnt++;
      if (SCurve_Test_Start) begin
        start_cnt++;
        check("point_stable", {DAC_Code, Channel_Sel}, last_exp);
      end
      if (Tag_wr_en) begin
        if (tag_cnt == 0) first_tag = Tag_Data;
        last_tag = Tag_Data;
        tag_cnt++;
        if (exp_q.size() == 0) check("tag_extra", exp_q.size(), 1);
        else begin
          last_exp = exp_q.pop_front();
          check("tag", Tag_Data, last_exp);
        end
      end
    end
  end

  task automatic clear_counts();
    tag_cnt = 0; cfg_req_cnt = 0; start_cnt = 0; done_cnt = 0;
  endtask

  task automatic drive_cfg(input bit mode, input int ch, input int st, input int sp, input int stp);
    Single_Chn_Mode = mode;
    Single_Chn      = 6'(ch);
    DAC_Start       = 10'(st);
    DAC_Stop        = 10'(sp);
    DAC_Step        = 10'(stp);
  endtask

  task automatic run_sweep(input string name, input bit mode, input int ch, input int st,
                           input int sp, input int stp);
    int n, budget, k;
    repeat (3) @(negedge Clk);
    exp_q.delete();
    build_model(mode, ch, st, sp, stp, n);
    clear_counts();
    drive_cfg(mode, ch, st, sp, stp);
    Sweep_Start = 1'b1;
    budget = n * (SETTLE + 12 + 2 * max_delay) + 40;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
      // Inputs must have been latched; disturbing them mid-sweep must not matter.
      if (k == 5) drive_cfg($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1023),
                            $urandom_range(0, 1023), $urandom_range(0, 1023));
    end while (!Sweep_Done && k < budget);
    check({name, "_done_seen"}, Sweep_Done, 1);
    Sweep_Start = 1'b0;
    repeat (4) @(negedge Clk);
    check({name, "_tags"}, tag_cnt, n);
    check({name, "_cfg_reqs"}, cfg_req_cnt, n);
    check({name, "_test_starts"}, start_cnt, n);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_busy_after"}, Busy, 0);
  endtask

  initial begin
    int k, saved;
    bit seen, mode;
    int ch, st, sp, stp;

    // reset state
    repeat (3) @(negedge Clk);
    check("reset_outputs", all_outs(), 0);
    check("reset_state", state_dbg, S_IDLE);
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_outputs", all_outs(), 0);

    // all-channel sweep, instant responses
    max_delay = 0;
    run_sweep("all_chn", 1'b0, 0, 100, 102, 1);
    check("all_chn_first", first_tag, 16'h1900);
    check("all_chn_last", last_tag, 16'h19BF);

    // single channel, coarse step up to the top code
    run_sweep("single_top", 1'b1, 5, 0, 1023, 256);
    check("single_top_last", last_tag, 16'hC005);

    // Stop < Start: Done two edges after the edge that samples the start
    repeat (3) @(negedge Clk);
    clear_counts();
    exp_q.delete();
    drive_cfg(1'b0, 0, 500, 499, 1);
    Sweep_Start = 1'b1;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!Sweep_Done && k < 20);
    check("empty_done_latency", k, 3);
    Sweep_Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("empty_cfg_reqs", cfg_req_cnt, 0);
    check("empty_done_pulses", done_cnt, 1);

    run_sweep("step0_single", 1'b1, 9, 7, 7, 0);
    run_sweep("near_top", 1'b1, 2, 1000, 1023, 20);
    run_sweep("overflow", 1'b1, 4, 1000, 1023, 1000);

    // settle timing and spurious One_Channel_Done during SETTLE
    auto_cfg = 1'b0;
    auto_done = 1'b0;
    repeat (3) @(negedge Clk);
    clear_counts();
    exp_q.delete();
    exp_q.push_back({10'd10, 6'd3});
    drive_cfg(1'b1, 3, 10, 10, 1);
    Sweep_Start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      seen = Config_Req;
    end
    check("timing_cfg_req", seen, 1);
    repeat (50) @(negedge Clk);
    check("timing_waits_cfg", start_cnt, 0);
    cfg_man = 1'b1;
    @(negedge Clk);
    cfg_man = 1'b0;
    k = 1;
    while (!SCurve_Test_Start && k < 100) begin
      if (k == 5) ocd_man = 1'b1;
      if (k == 6) ocd_man = 1'b0;
      @(negedge Clk);
      k++;
    end
    check("start_latency", k, SETTLE + 2);
    repeat (10) @(negedge Clk);
    check("spurious_ignored_busy", Busy, 1);
    check("spurious_ignored_done", done_cnt, 0);
    ocd_man = 1'b1;
    @(negedge Clk);
    ocd_man = 1'b0;
    k = 0;
    while (!Sweep_Done && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("timing_done", Sweep_Done, 1);
    check("timing_tags", tag_cnt, 1);
    Sweep_Start = 1'b0;

    // abort while waiting for the test stage
    auto_cfg = 1'b1;
    max_delay = 2;
    repeat (3) @(negedge Clk);
    clear_counts();
    exp_q.delete();
    exp_q.push_back({10'd200, 6'd0});
    drive_cfg(1'b0, 0, 200, 210, 1);
    Sweep_Start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = SCurve_Test_Start;
    end
    check("abort_reached_start", seen, 1);
    @(negedge Clk);
    Sweep_Abort = 1'b1;
    @(negedge Clk);
    Sweep_Abort = 1'b0;
    check("abort_state", state_dbg, S_IDLE);
    check("abort_busy", Busy, 0);
    check("abort_done", Sweep_Done, 1);
    check("abort_strobes", {Config_Req, SCurve_Test_Start, Tag_wr_en}, 0);
    saved = cfg_req_cnt;
    ocd_man = 1'b1;
    @(negedge Clk);
    ocd_man = 1'b0;
    repeat (20) @(negedge Clk);
    check("abort_no_activity", cfg_req_cnt, saved);
    check("abort_done_pulses", done_cnt, 1);
    check("abort_idle_busy", Busy, 0);
    Sweep_Start = 1'b0;
    auto_done = 1'b1;

    // reset mid-sweep with Sweep_Start held high across release
    repeat (3) @(negedge Clk);
    clear_counts();
    exp_q.delete();
    build_model(1'b0, 0, 300, 301, 1, k);
    drive_cfg(1'b0, 0, 300, 301, 1);
    Sweep_Start = 1'b1;
    repeat (150) @(negedge Clk);
    check("pre_reset_busy", Busy, 1);
    done_cnt = 0;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", all_outs(), 0);
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    exp_q.delete();
    clear_counts();
    repeat (30) @(negedge Clk);
    check("held_start_busy", Busy, 0);
    check("held_start_cfg", cfg_req_cnt, 0);
    check("reset_no_done", done_cnt, 0);
    Sweep_Start = 1'b0;
    run_sweep("after_reset", 1'b1, 17, 40, 60, 10);

    // randomized sweeps
    for (int i = 0; i < 6; i++) begin
      mode = 1'($urandom_range(0, 1));
      ch = $urandom_range(0, 63);
      max_delay = $urandom_range(0, 3);
      if (mode) begin
        st  = $urandom_range(0, 1023);
        stp = $urandom_range(0, 1023);
        if (stp < 16) begin
          sp = st + $urandom_range(0, 20);
          if (sp > 1023) sp = 1023;
        end else begin
          sp = $urandom_range(0, 1023);
        end
      end else begin
        st  = $urandom_range(0, 1020);
        stp = $urandom_range(0, 3);
        sp  = st + $urandom_range(0, 1);
      end
      run_sweep($sformatf("rand%0d", i), mode, ch, st, sp, stp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
